// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU, its command sequencer and their benches.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  // ALU opcodes; all eight encodings are legal.
  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_SLL = 3'b101;
  localparam logic [OP_W-1:0] ALU_SRL = 3'b110;
  localparam logic [OP_W-1:0] ALU_SLT = 3'b111;

  // Command sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_ack_timer.sv
// Ack timeout counter: cleared on load, advanced while counting, flags expiry
// on the last permitted wait cycle (count value ACK_TIMEOUT-1).
module alu_ack_timer #(
  parameter int ACK_TIMEOUT = 16  // must be >= 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Wait-cycle counter; load has priority over count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Upstream command stage for the ALU: accepts one command, drives the ALU,
// waits for ack (bounded by a timeout) and returns the result over a
// valid/ready response port. One command in flight; all outputs registered.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16  // must be >= 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_e,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_err,
  output logic [7:0]        err_cnt
);

  seq_state_t state;
  logic       accept;
  logic       expire;

  // cmd_ready is registered, so the handshake never depends combinationally on cmd_valid.
  assign accept = (state == IDLE) && cmd_valid && cmd_ready;

  alu_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .count (state == WAIT),
    .expire(expire)
  );

  // Command FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset as well, not only the control bits,
      // so every output reads 0 from the moment reset asserts.
      state     <= IDLE;
      cmd_ready <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_e     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_op    <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // reads the pre-edge value regardless of statement order.
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_op    <= cmd_op;
            rsp_op    <= cmd_op;
            alu_e     <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= WAIT;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WAIT: begin
          // Ack beats a simultaneous timeout.
          if (alu_ack) begin
            rsp_y     <= alu_y;
            rsp_err   <= 1'b0;
            alu_e     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (expire) begin
            rsp_y     <= '0;
            rsp_err   <= 1'b1;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            alu_e     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
